// File: rtl/game_pkg.sv
// Shared types and constants for the 2048 game logic.
package game_pkg;

    localparam int unsigned GOAL_W = 4;
    localparam int unsigned TILE_W = 12;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        StIdle,
        StSpawn,
        StCheck,
        StReady,
        StMove,
        StWon,
        StLost,
        StFault
    } ctrl_state_t;

    // States that wait on a *_done handshake and are guarded by the watchdog.
    function automatic logic is_wait_state(ctrl_state_t s);
        return (s == StSpawn) || (s == StCheck) || (s == StMove);
    endfunction

endpackage

// File: rtl/done_watchdog.sv
// Cycle counter cleared on entry to a wait state; flags when the wait has
// lasted DONE_TIMEOUT cycles.
module done_watchdog #(
    parameter int unsigned DONE_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(DONE_TIMEOUT);
    localparam logic [CntW-1:0] Last = CntW'(DONE_TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count reads 0 in the entry cycle, so it hits Last in the final allowed cycle.
    assign expired = enable && (cnt_q == Last);

    // Next count: restart on entry, hold at Last, idle at zero outside wait states.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Game lifecycle sequencer: new-game setup, move acceptance and ordering of the
// shift/merge, spawn and win/lose check handshakes.
module game_controller
    import game_pkg::*;
#(
    parameter int unsigned DONE_TIMEOUT = 1024,
    parameter int unsigned MOVE_CNT_W   = 16,
    parameter int unsigned INIT_TILES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [GOAL_W-1:0]     goal_in,
    input  logic                  dir_valid,
    input  logic [1:0]            dir,
    output logic                  dir_ready,
    output logic                  move_start,
    output logic [1:0]            move_dir,
    input  logic                  move_done,
    input  logic                  move_changed,
    output logic                  spawn_start,
    input  logic                  spawn_done,
    output logic                  check_start,
    input  logic                  check_done,
    input  logic                  win_in,
    input  logic                  lose_in,
    output logic [GOAL_W-1:0]     goal_out,
    output logic [MOVE_CNT_W-1:0] move_count,
    output logic                  playing,
    output logic                  won,
    output logic                  lost,
    output logic                  fault
);

    localparam int unsigned SpawnW = $clog2(INIT_TILES + 1);

    ctrl_state_t           state_q, state_d;
    logic [SpawnW-1:0]     spawn_left_q, spawn_left_d;
    logic [GOAL_W-1:0]     goal_q, goal_d;
    logic [MOVE_CNT_W-1:0] count_q, count_d;
    dir_t                  move_dir_q, move_dir_d;
    logic                  move_start_q, move_start_d;
    logic                  spawn_start_q, spawn_start_d;
    logic                  check_start_q, check_start_d;
    logic                  start_ok;
    logic                  wd_clear;
    logic                  expired;

    assign start_ok = start && (state_q inside {StIdle, StReady, StWon, StLost, StFault});
    // Every entry (or re-entry) into a wait state is marked by its start pulse.
    assign wd_clear = move_start_d | spawn_start_d | check_start_d;

    done_watchdog #(
        .DONE_TIMEOUT(DONE_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (is_wait_state(state_q)),
        .expired (expired)
    );

    // Next-state, handshake pulses and latched game data.
    always_comb begin
        state_d       = state_q;
        spawn_left_d  = spawn_left_q;
        goal_d        = goal_q;
        count_d       = count_q;
        move_dir_d    = move_dir_q;
        move_start_d  = 1'b0;
        spawn_start_d = 1'b0;
        check_start_d = 1'b0;

        if (start_ok) begin
            // A new game wins over a direction offered in the same READY cycle.
            goal_d        = goal_in;
            count_d       = '0;
            spawn_left_d  = SpawnW'(INIT_TILES);
            state_d       = StSpawn;
            spawn_start_d = 1'b1;
        end else begin
            case (state_q)
                StReady: begin
                    if (dir_valid) begin
                        move_dir_d   = dir_t'(dir);
                        state_d      = StMove;
                        move_start_d = 1'b1;
                    end
                end
                StMove: begin
                    // Done in the pulse cycle itself is not a valid response.
                    if (move_done && !move_start_q) begin
                        if (move_changed) begin
                            if (count_q != {MOVE_CNT_W{1'b1}}) begin
                                count_d = count_q + 1'b1;
                            end
                            spawn_left_d  = SpawnW'(1);
                            state_d       = StSpawn;
                            spawn_start_d = 1'b1;
                        end else begin
                            state_d = StReady;
                        end
                    end else if (expired) begin
                        state_d = StFault;
                    end
                end
                StSpawn: begin
                    if (spawn_done && !spawn_start_q) begin
                        spawn_left_d = spawn_left_q - 1'b1;
                        if (spawn_left_d != '0) begin
                            spawn_start_d = 1'b1;
                        end else begin
                            state_d       = StCheck;
                            check_start_d = 1'b1;
                        end
                    end else if (expired) begin
                        state_d = StFault;
                    end
                end
                StCheck: begin
                    if (check_done && !check_start_q) begin
                        if (win_in) begin
                            state_d = StWon;
                        end else if (lose_in) begin
                            state_d = StLost;
                        end else begin
                            state_d = StReady;
                        end
                    end else if (expired) begin
                        state_d = StFault;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            spawn_left_q  <= '0;
            goal_q        <= '0;
            count_q       <= '0;
            move_dir_q    <= DIR_UP;
            move_start_q  <= 1'b0;
            spawn_start_q <= 1'b0;
            check_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            spawn_left_q  <= spawn_left_d;
            goal_q        <= goal_d;
            count_q       <= count_d;
            move_dir_q    <= move_dir_d;
            move_start_q  <= move_start_d;
            spawn_start_q <= spawn_start_d;
            check_start_q <= check_start_d;
        end
    end

    assign dir_ready   = (state_q == StReady);
    assign move_start  = move_start_q;
    assign spawn_start = spawn_start_q;
    assign check_start = check_start_q;
    assign move_dir    = move_dir_q;
    assign goal_out    = goal_q;
    assign move_count  = count_q;
    assign playing     = is_wait_state(state_q) || (state_q == StReady);
    assign won         = (state_q == StWon);
    assign lost        = (state_q == StLost);
    assign fault       = (state_q == StFault);

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a status-level expectation model.
module tb_game_controller;

    localparam int DT = 8;
    localparam int CW = 2;
    localparam int IT = 2;
    localparam int MaxCnt = (1 << CW) - 1;

    // Expected status codes
    localparam int SIdle = 0;
    localparam int SPlay = 1;
    localparam int SWon  = 2;
    localparam int SLost = 3;
    localparam int SFlt  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    goal_in = '0;
    logic          dir_valid = 1'b0;
    logic [1:0]    dir = '0;
    logic          dir_ready;
    logic          move_start;
    logic [1:0]    move_dir;
    logic          move_done = 1'b0;
    logic          move_changed = 1'b0;
    logic          spawn_start;
    logic          spawn_done = 1'b0;
    logic          check_start;
    logic          check_done = 1'b0;
    logic          win_in = 1'b0;
    logic          lose_in = 1'b0;
    logic [3:0]    goal_out;
    logic [CW-1:0] move_count;
    logic          playing, won, lost, fault;

    game_controller #(
        .DONE_TIMEOUT(DT),
        .MOVE_CNT_W  (CW),
        .INIT_TILES  (IT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .goal_in     (goal_in),
        .dir_valid   (dir_valid),
        .dir         (dir),
        .dir_ready   (dir_ready),
        .move_start  (move_start),
        .move_dir    (move_dir),
        .move_done   (move_done),
        .move_changed(move_changed),
        .spawn_start (spawn_start),
        .spawn_done  (spawn_done),
        .check_start (check_start),
        .check_done  (check_done),
        .win_in      (win_in),
        .lose_in     (lose_in),
        .goal_out    (goal_out),
        .move_count  (move_count),
        .playing     (playing),
        .won         (won),
        .lost        (lost),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_move = 0, n_spawn = 0, n_check = 0;
    bit cmp_en = 1'b0;

    int exp_goal = 0, exp_count = 0, exp_dir = 0, exp_status = SIdle, exp_ready = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus pulse counting.
    always @(negedge clk) begin
        n_move  += int'(move_start);
        n_spawn += int'(spawn_start);
        n_check += int'(check_start);
        if (cmp_en) begin
            chk("goal_out", int'(goal_out), exp_goal);
            chk("move_count", int'(move_count), exp_count);
            chk("move_dir", int'(move_dir), exp_dir);
            chk("dir_ready", int'(dir_ready), exp_ready);
            chk("playing", int'(playing), int'(exp_status == SPlay));
            chk("won", int'(won), int'(exp_status == SWon));
            chk("lost", int'(lost), int'(exp_status == SLost));
            chk("fault", int'(fault), int'(exp_status == SFlt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a DUT signal: 0 spawn_start, 1 check_start, 2 dir_ready.
    task automatic wait_sig(input int which, input string name);
        logic s;
        s = 1'b0;
        for (int i = 0; i < 64; i++) begin
            s = (which == 0) ? spawn_start : (which == 1) ? check_start : dir_ready;
            if (s) break;
            tick();
        end
        chk(name, int'(s), 1);
    endtask

    task automatic do_start(input int g);
        start   = 1'b1;
        goal_in = 4'(g);
        tick();
        start      = 1'b0;
        exp_goal   = g;
        exp_count  = 0;
        exp_status = SPlay;
        exp_ready  = 0;
        chk("spawn_after_start", int'(spawn_start), 1);
    endtask

    task automatic serve_spawns(input int n, input bit poke_start);
        for (int k = 0; k < n; k++) begin
            wait_sig(0, "wait_spawn_start");
            tick();
            spawn_done = 1'b1;
            if (poke_start && k == 0) begin
                start   = 1'b1;
                goal_in = 4'd12;
            end
            tick();
            spawn_done = 1'b0;
            start      = 1'b0;
        end
        chk("check_after_last_spawn", int'(check_start), 1);
    endtask

    task automatic serve_check(input bit w, input bit l);
        wait_sig(1, "wait_check_start");
        tick();
        check_done = 1'b1;
        win_in     = w;
        lose_in    = l;
        tick();
        check_done = 1'b0;
        win_in     = 1'b0;
        lose_in    = 1'b0;
        exp_status = w ? SWon : (l ? SLost : SPlay);
        exp_ready  = (!w && !l) ? 1 : 0;
    endtask

    task automatic new_game(input int g, input bit poke, input bit w, input bit l);
        int s0, c0;
        s0 = n_spawn;
        c0 = n_check;
        do_start(g);
        serve_spawns(IT, poke);
        serve_check(w, l);
        chk("new_game_spawns", n_spawn - s0, IT);
        chk("new_game_checks", n_check - c0, 1);
    endtask

    task automatic transfer(input int d);
        wait_sig(2, "wait_dir_ready");
        dir_valid = 1'b1;
        dir       = 2'(d);
        tick();
        dir_valid = 1'b0;
        exp_dir   = d;
        exp_ready = 0;
        chk("move_start_latency", int'(move_start), 1);
    endtask

    task automatic do_move(input int d, input bit changed, input bit early);
        int s0, c0, m0;
        s0 = n_spawn;
        c0 = n_check;
        m0 = n_move;
        transfer(d);
        if (early) begin
            // Done coincident with move_start must be ignored.
            move_done    = 1'b1;
            move_changed = 1'b1;
            tick();
            move_done = 1'b0;
            tick();
        end else begin
            tick();
        end
        move_done    = 1'b1;
        move_changed = changed;
        tick();
        move_done    = 1'b0;
        move_changed = 1'b0;
        if (changed) begin
            if (exp_count < MaxCnt) exp_count++;
            chk("spawn_after_move", int'(spawn_start), 1);
            serve_spawns(1, 1'b0);
            serve_check(1'b0, 1'b0);
            chk("move_spawns", n_spawn - s0, 1);
            chk("move_checks", n_check - c0, 1);
        end else begin
            exp_ready = 1;
            chk("ready_after_nochange", int'(dir_ready), 1);
            tick();
            chk("nochange_spawns", n_spawn - s0, 0);
            chk("nochange_checks", n_check - c0, 0);
        end
        chk("move_pulses", n_move - m0, 1);
    endtask

    initial begin
        int m0, s0;
        rst = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (3) tick();
        chk("reset_goal", int'(goal_out), 0);
        chk("reset_count", int'(move_count), 0);
        chk("reset_playing", int'(playing), 0);
        rst = 1'b1;
        tick();

        // Game A: goal 9, two initial spawns, into READY.
        new_game(9, 1'b0, 1'b0, 1'b0);
        chk("gameA_goal", int'(goal_out), 9);
        chk("gameA_ready", int'(dir_ready), 1);
        do_move(2, 1'b1, 1'b0);
        chk("gameA_dir_left", int'(move_dir), 2);
        chk("gameA_count1", int'(move_count), 1);
        do_move(1, 1'b0, 1'b0);
        chk("gameA_count_held", int'(move_count), 1);
        do_move(3, 1'b1, 1'b1);
        chk("gameA_count2", int'(move_count), 2);

        // Game B: start during SPAWN ignored, then win and lose together -> WON.
        new_game(5, 1'b1, 1'b1, 1'b1);
        chk("gameB_goal_kept", int'(goal_out), 5);
        chk("gameB_won", int'(won), 1);
        chk("gameB_not_lost", int'(lost), 0);
        m0 = n_move;
        dir_valid = 1'b1;
        repeat (3) tick();
        dir_valid = 1'b0;
        tick();
        chk("won_no_move", n_move - m0, 0);

        // Game C: watchdog on a withheld move_done.
        new_game(7, 1'b0, 1'b0, 1'b0);
        chk("gameC_count0", int'(move_count), 0);
        transfer(0);
        repeat (DT - 1) tick();
        chk("fault_not_yet", int'(fault), 0);
        tick();
        exp_status = SFlt;
        chk("fault_set", int'(fault), 1);
        chk("fault_not_playing", int'(playing), 0);

        // Game D: restart from FAULT, four changed moves saturate the counter.
        new_game(10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_move(i, 1'b1, 1'b0);
        chk("count_saturated", int'(move_count), 3);

        // Reset in the middle of a move.
        transfer(3);
        tick();
        rst = 1'b0;
        #1;
        exp_goal   = 0;
        exp_count  = 0;
        exp_dir    = 0;
        exp_status = SIdle;
        exp_ready  = 0;
        chk("rst_move_dir", int'(move_dir), 0);
        chk("rst_goal", int'(goal_out), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_move_start", int'(move_start), 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        s0 = n_spawn;
        repeat (4) tick();
        chk("rst_no_pending_spawn", n_spawn - s0, 0);

        // Game E: lose.
        new_game(4, 1'b0, 1'b0, 1'b1);
        chk("gameE_lost", int'(lost), 1);
        tick();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got 0, want 1");
        $fatal(1);
    end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level sequencing FSM for the 2048 game logic. It owns the game lifecycle: new-game setup, player move acceptance, and ordering the shift/merge datapath, the tile spawner and the win/lose checkers through start/done handshakes. It latches the goal code used by the goal checker, counts effective moves, and reports playing/won/lost/fault status to the display and top level.

## Interface
- DONE_TIMEOUT, 1024: maximum cycles to wait for any `*_done` before faulting; must be ≥ 2.
- MOVE_CNT_W, 16: move counter width.
- INIT_TILES, 2: tiles spawned at new game; must be ≥ 1.

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  new-game request, single-cycle pulse
- goal_in  in  4  goal code; target tile = 2^(goal+2)
- dir_valid  in  1  player direction valid
- dir  in  2  00 up, 01 down, 10 left, 11 right
- dir_ready  out  1  controller accepts a direction
- move_start  out  1  one-cycle pulse to shift/merge datapath
- move_dir  out  2  direction for current move, stable for the whole move
- move_done  in  1  datapath finished, single-cycle pulse
- move_changed  in  1  board changed by move, sampled with move_done
- spawn_start  out  1  one-cycle pulse to tile spawner
- spawn_done  in  1  spawner finished
- check_start  out  1  one-cycle pulse to win/lose checkers
- check_done  in  1  checkers' results valid
- win_in  in  1  goal tile present, sampled with check_done
- lose_in  in  1  no legal move, sampled with check_done
- goal_out  out  4  latched goal code
- move_count  out  MOVE_CNT_W  effective moves this game, saturating
- playing, won, lost, fault  out  1  status flags

## Operation
- States: IDLE, SPAWN, CHECK, READY, MOVE, WON, LOST, FAULT.
- start is honoured in IDLE, READY, WON, LOST and FAULT, and ignored in MOVE, SPAWN and CHECK. On start: goal_out ← goal_in, move_count ← 0, spawn_left ← INIT_TILES, then go to SPAWN.
- SPAWN: on spawn_done, decrement spawn_left. If the result is nonzero, stay in SPAWN with a new spawn_start pulse. Otherwise go to CHECK.
- CHECK: on check_done, go to WON if win_in, else LOST if lose_in, else READY. win_in has priority when both are set.
- READY: dir_ready = 1. A transfer (dir_valid & dir_ready) captures dir into move_dir and goes to MOVE.
- MOVE: on move_done with move_changed = 1, increment move_count (saturating at all ones), set spawn_left ← 1 and go to SPAWN. With move_changed = 0, go back to READY: no count, no spawn, no check.
- WON and LOST hold until start. The game is not continued after a win.
- Watchdog: in MOVE, SPAWN and CHECK, count cycles since entry. If the count reaches DONE_TIMEOUT without the matching done, go to FAULT. Done inputs not matching the current state are ignored.
- Status flags:
  - playing = 1 in SPAWN, CHECK, READY, MOVE.
  - won, lost and fault = 1 only in their own state.

## Timing
- Reset values: state IDLE; all outputs 0, including goal_out, move_dir and move_count. Reset asserted mid-handshake aborts immediately and no start pulse is left pending.
- Each `*_start` is registered and is high exactly in the first cycle of its wait state. A wait state re-entered for another spawn emits a new pulse.
- A done arriving in the same cycle as its start pulse is ignored. Done is valid from the cycle after the pulse.
- Latencies:
  - Transfer at cycle T: move_start at T+1.
  - move_done at D: spawn_start or dir_ready at D+1.
  - spawn_done (last tile) at S: check_start at S+1.
  - check_done at C: status at C+1.
- move_count updates at D+1. goal_out updates the cycle after start is accepted.
- dir_ready drops the cycle after a transfer. dir_valid while not ready is not buffered.

## Structure
- Shared package `game_pkg`: dir_t enum (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT), ctrl_state_t enum, goal code width constant (4) and tile width constant (12).
- Sub-module `done_watchdog`: clear-on-entry counter with an `expired` output, parameterised by DONE_TIMEOUT.

## Test plan
- Reset, then start with goal_in=9 → spawn_start twice, one check_start; with win=lose=0 reach READY; goal_out=9, move_count=0.
- From READY, dir=10 with move_changed=1 → move_start one cycle after the transfer, move_dir=10, one spawn, one check, move_count=1. Repeat with move_changed=0 → no spawn or check, READY at D+1, count unchanged.
- check_done with win_in=1 and lose_in=1 together → WON (won=1, lost=0). Then dir_valid → dir_ready stays 0. Then start → new game, move_count=0.
- move_done withheld for DONE_TIMEOUT cycles in MOVE → fault=1, playing=0. start → SPAWN.
- start pulsed during SPAWN → ignored, spawn sequence completes normally. rst low mid-MOVE → every output 0 immediately, IDLE.
- MOVE_CNT_W=2, four changed moves → move_count saturates at 3.
